// File: rtl/fm_radio_pkg.sv
// Shared types and fixed-point helpers for the FM radio filter chain.
// Helpers work on a wide signed container so they serve any DATA_WIDTH up to 64.
package fm_radio_pkg;

   typedef enum logic [1:0] {
      READ  = 2'd0,
      MAC   = 2'd1,
      WRITE = 2'd2
   } state_t;

   localparam int MAX_W = 128;

   // Round toward zero: negative products get a bias of 2^frac_bits-1 before the shift.
   function automatic logic signed [MAX_W-1:0] dequantize(input logic signed [MAX_W-1:0] p,
                                                          input int frac_bits);
      logic signed [MAX_W-1:0] bias;
      bias = (MAX_W'(1) << frac_bits) - MAX_W'(1);
      if (p < 0) return (p + bias) >>> frac_bits;
      return p >>> frac_bits;
   endfunction

   function automatic logic signed [MAX_W-1:0] saturate(input logic signed [MAX_W-1:0] acc,
                                                        input int width);
      logic signed [MAX_W-1:0] max_v;
      logic signed [MAX_W-1:0] min_v;
      max_v = (MAX_W'(1) << (width - 1)) - MAX_W'(1);
      min_v = -max_v - MAX_W'(1);
      if (acc > max_v) return max_v;
      if (acc < min_v) return min_v;
      return acc;
   endfunction

endpackage

// File: rtl/iir_mac_lane.sv
// One channel of the Direct-Form-I datapath: x/y histories, a one-tap-per-cycle
// MAC into a guarded accumulator, and the final reduction to DATA_WIDTH.
module iir_mac_lane
   import fm_radio_pkg::*;
#(
   parameter int TAPS       = 2,
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_BITS  = 10,
   parameter int SATURATE   = 0,
   parameter logic [0:TAPS-1][DATA_WIDTH-1:0] B_COEFFS = '0,
   parameter logic [0:TAPS-1][DATA_WIDTH-1:0] A_COEFFS = '0
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      i_shift_x,
   input  logic [DATA_WIDTH-1:0]     i_x,
   input  logic                      i_clear,
   input  logic                      i_mac_en,
   input  logic [$clog2(TAPS)-1:0]   i_tap,
   input  logic                      i_commit,
   output logic [DATA_WIDTH-1:0]     o_y
);

   localparam int TAP_W = $clog2(TAPS);
   localparam int ACC_W = DATA_WIDTH + $clog2(2 * TAPS);

   logic signed [DATA_WIDTH-1:0] r_x_h [TAPS];
   logic signed [DATA_WIDTH-1:0] r_y_h [TAPS-1];  // r_y_h[k-1] holds y[n-k]
   logic signed [ACC_W-1:0]      r_acc;
   logic signed [DATA_WIDTH-1:0] r_y;

   logic [TAP_W-1:0]               w_y_idx;
   logic signed [DATA_WIDTH-1:0]   w_b;
   logic signed [DATA_WIDTH-1:0]   w_a;
   logic signed [DATA_WIDTH-1:0]   w_x_sel;
   logic signed [DATA_WIDTH-1:0]   w_y_sel;
   logic signed [2*DATA_WIDTH-1:0] w_prod_b;
   logic signed [2*DATA_WIDTH-1:0] w_prod_a;
   logic signed [DATA_WIDTH-1:0]   w_term_b;
   logic signed [DATA_WIDTH-1:0]   w_term_a;
   logic signed [DATA_WIDTH-1:0]   w_reduced;

   // Tap 0 has no feedback term; a[0] never reaches the accumulator.
   always_comb begin
      w_y_idx  = (i_tap == '0) ? '0 : i_tap - TAP_W'(1);
      w_b      = B_COEFFS[i_tap];
      w_a      = (i_tap == '0) ? '0 : A_COEFFS[i_tap];
      w_x_sel  = r_x_h[i_tap];
      w_y_sel  = (i_tap == '0) ? '0 : r_y_h[w_y_idx];
      w_prod_b = (2*DATA_WIDTH)'(w_b) * (2*DATA_WIDTH)'(w_x_sel);
      w_prod_a = (2*DATA_WIDTH)'(w_a) * (2*DATA_WIDTH)'(w_y_sel);
      w_term_b = DATA_WIDTH'(dequantize(MAX_W'(w_prod_b), FRAC_BITS));
      w_term_a = DATA_WIDTH'(dequantize(MAX_W'(w_prod_a), FRAC_BITS));
      if (SATURATE != 0) w_reduced = DATA_WIDTH'(saturate(MAX_W'(r_acc), DATA_WIDTH));
      else               w_reduced = r_acc[DATA_WIDTH-1:0];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < TAPS; k++)     r_x_h[k] <= '0;
         for (int k = 0; k < TAPS - 1; k++) r_y_h[k] <= '0;
         r_acc <= '0;
         r_y   <= '0;
      end else begin
         if (i_shift_x) begin
            r_x_h[0] <= i_x;
            for (int k = 1; k < TAPS; k++) r_x_h[k] <= r_x_h[k-1];
         end
         if (i_clear)       r_acc <= '0;
         else if (i_mac_en) r_acc <= r_acc + ACC_W'(w_term_b) + ACC_W'(w_term_a);
         if (i_commit) begin
            r_y      <= w_reduced;
            r_y_h[0] <= w_reduced;
            for (int k = 1; k < TAPS - 1; k++) r_y_h[k] <= r_y_h[k-1];
         end
      end
   end

   assign o_y = r_y;

endmodule

// File: rtl/iir_multichannel.sv
// Lock-stepped multichannel DF-I IIR between FIFOs: READ (with decimation),
// MAC one tap per cycle, WRITE when every output FIFO has room.
module iir_multichannel
   import fm_radio_pkg::*;
#(
   parameter int CHANNELS   = 2,
   parameter int TAPS       = 2,
   parameter int DECIMATION = 1,
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_BITS  = 10,
   parameter int SATURATE   = 0,
   parameter logic [0:TAPS-1][DATA_WIDTH-1:0] B_COEFFS = {32'd178, 32'd178},
   parameter logic [0:TAPS-1][DATA_WIDTH-1:0] A_COEFFS = {32'd0, 32'd666}
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [CHANNELS*DATA_WIDTH-1:0] x_in,
   input  logic [CHANNELS-1:0]            x_empty,
   output logic                           x_rd_en,
   output logic [CHANNELS*DATA_WIDTH-1:0] y_out,
   input  logic [CHANNELS-1:0]            y_full,
   output logic                           y_wr_en,
   output logic [1:0]                     o_dbg_state
);

   localparam int TAP_W = $clog2(TAPS);
   localparam int DEC_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

   state_t           r_state;
   state_t           w_next;
   logic [DEC_W-1:0] r_dec_cnt;
   logic [TAP_W-1:0] r_tap_cnt;
   logic             r_y_wr_en;
   logic             w_rd;
   logic             w_clear;
   logic             w_mac_en;
   logic             w_commit;
   logic             w_last_dec;

   // Handshakes: a read happens in any READ cycle where every input FIFO is
   // non-empty; a write happens in a WRITE cycle where no output FIFO is full.
   always_comb begin
      w_next     = r_state;
      w_rd       = 1'b0;
      w_clear    = 1'b0;
      w_mac_en   = 1'b0;
      w_commit   = 1'b0;
      w_last_dec = (r_dec_cnt == DEC_W'(DECIMATION - 1));
      case (r_state)
         READ: begin
            if (x_empty == '0) begin
               w_rd = 1'b1;
               if (w_last_dec) begin
                  w_clear = 1'b1;
                  w_next  = MAC;
               end
            end
         end
         MAC: begin
            w_mac_en = 1'b1;
            if (r_tap_cnt == TAP_W'(TAPS - 1)) w_next = WRITE;
         end
         WRITE: begin
            if (y_full == '0) begin
               w_commit = 1'b1;
               w_next   = READ;
            end
         end
         default: w_next = READ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= READ;
         r_dec_cnt <= '0;
         r_tap_cnt <= '0;
         r_y_wr_en <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_y_wr_en <= w_commit;
         if (w_rd) r_dec_cnt <= w_last_dec ? '0 : r_dec_cnt + DEC_W'(1);
         if (w_mac_en) r_tap_cnt <= (r_tap_cnt == TAP_W'(TAPS - 1)) ? '0 : r_tap_cnt + TAP_W'(1);
         else          r_tap_cnt <= '0;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      iir_mac_lane #(
         .TAPS       (TAPS),
         .DATA_WIDTH (DATA_WIDTH),
         .FRAC_BITS  (FRAC_BITS),
         .SATURATE   (SATURATE),
         .B_COEFFS   (B_COEFFS),
         .A_COEFFS   (A_COEFFS)
      ) u_lane (
         .clock     (clock),
         .reset     (reset),
         .i_shift_x (w_rd),
         .i_x       (x_in[c*DATA_WIDTH +: DATA_WIDTH]),
         .i_clear   (w_clear),
         .i_mac_en  (w_mac_en),
         .i_tap     (r_tap_cnt),
         .i_commit  (w_commit),
         .o_y       (y_out[c*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   assign x_rd_en     = w_rd;
   assign y_wr_en     = r_y_wr_en;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_iir_multichannel.sv
// Bench for iir_multichannel: four configurations share clock and reset;
// a DF-I reference model feeds an expected-output queue checked on every y_wr_en.
module tb_iir_multichannel;
   localparam int DW = 32;
   localparam int NI = 4;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic [2*DW-1:0] x_in      [NI];
   logic [1:0]      x_empty   [NI];
   logic [1:0]      y_full    [NI];
   logic            x_rd_en   [NI];
   logic            y_wr_en   [NI];
   logic [2*DW-1:0] y_out     [NI];
   logic [1:0]      dbg_state [NI];

   iir_multichannel u_def (
      .clock(clock), .reset(reset), .x_in(x_in[0]), .x_empty(x_empty[0]), .x_rd_en(x_rd_en[0]),
      .y_out(y_out[0]), .y_full(y_full[0]), .y_wr_en(y_wr_en[0]), .o_dbg_state(dbg_state[0]));

   iir_multichannel #(.SATURATE(1), .B_COEFFS({32'd1024, 32'd1024}), .A_COEFFS({32'd0, 32'd0})) u_sat (
      .clock(clock), .reset(reset), .x_in(x_in[1]), .x_empty(x_empty[1]), .x_rd_en(x_rd_en[1]),
      .y_out(y_out[1]), .y_full(y_full[1]), .y_wr_en(y_wr_en[1]), .o_dbg_state(dbg_state[1]));

   iir_multichannel #(.SATURATE(0), .B_COEFFS({32'd1024, 32'd1024}), .A_COEFFS({32'd0, 32'd0})) u_wrap (
      .clock(clock), .reset(reset), .x_in(x_in[2]), .x_empty(x_empty[2]), .x_rd_en(x_rd_en[2]),
      .y_out(y_out[2]), .y_full(y_full[2]), .y_wr_en(y_wr_en[2]), .o_dbg_state(dbg_state[2]));

   iir_multichannel #(.DECIMATION(4)) u_dec (
      .clock(clock), .reset(reset), .x_in(x_in[3]), .x_empty(x_empty[3]), .x_rd_en(x_rd_en[3]),
      .y_out(y_out[3]), .y_full(y_full[3]), .y_wr_en(y_wr_en[3]), .o_dbg_state(dbg_state[3]));

   // Reference model configuration per instance (FRAC_BITS = 10, TAPS = 2 everywhere)
   longint mb0  [NI] = '{178, 1024, 1024, 178};
   longint mb1  [NI] = '{178, 1024, 1024, 178};
   longint ma1  [NI] = '{666, 0, 0, 666};
   int     msat [NI] = '{0, 1, 0, 0};
   int     mdec [NI] = '{1, 1, 1, 4};

   longint mx0  [NI][2];
   longint mx1  [NI][2];
   longint my1  [NI][2];
   int     mcnt [NI];

   logic [2*DW-1:0] exp_q[$];
   logic [2*DW-1:0] mon_exp;
   logic [2*DW-1:0] last_y [NI];
   int rd_cnt [NI];
   int wr_cnt [NI];
   int active;
   int checks;
   int failures;

   function automatic longint deq(input longint p);
      longint q;
      q = p / 64'sd1024;
      return longint'($signed(q[31:0]));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         mcnt[i] = 0;
         for (int c = 0; c < 2; c++) begin
            mx0[i][c] = 0;
            mx1[i][c] = 0;
            my1[i][c] = 0;
         end
      end
      exp_q.delete();
   endtask

   task automatic model_read(input int inst, input logic [31:0] x0, input logic [31:0] x1);
      logic [31:0]     xv [2];
      logic [2*DW-1:0] e;
      longint          acc;
      logic [31:0]     r;
      xv[0] = x0;
      xv[1] = x1;
      e = '0;
      for (int c = 0; c < 2; c++) begin
         mx1[inst][c] = mx0[inst][c];
         mx0[inst][c] = longint'($signed(xv[c]));
      end
      mcnt[inst]++;
      if (mcnt[inst] == mdec[inst]) begin
         mcnt[inst] = 0;
         for (int c = 0; c < 2; c++) begin
            acc = deq(mb0[inst] * mx0[inst][c]) + deq(mb1[inst] * mx1[inst][c]) + deq(ma1[inst] * my1[inst][c]);
            if (msat[inst] != 0 && acc > 64'sd2147483647)       r = 32'h7FFF_FFFF;
            else if (msat[inst] != 0 && acc < -64'sd2147483648) r = 32'h8000_0000;
            else                                                r = acc[31:0];
            my1[inst][c] = longint'($signed(r));
            e[c*32 +: 32] = r;
         end
         exp_q.push_back(e);
      end
   endtask

   always @(posedge clock) begin
      for (int i = 0; i < NI; i++)
         if (x_rd_en[i] === 1'b1 && reset === 1'b0) rd_cnt[i]++;
   end

   always @(negedge clock) begin
      for (int i = 0; i < NI; i++) begin
         if (y_wr_en[i] === 1'b1) begin
            wr_cnt[i]++;
            last_y[i] = y_out[i];
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL scoreboard_unexpected inst=%0d got=%h expected=no_output", i, y_out[i]);
            end else begin
               mon_exp = exp_q.pop_front();
               if (i != active || y_out[i] !== mon_exp) begin
                  failures++;
                  $display("FAIL scoreboard inst=%0d got=%h expected=%h (active inst %0d)", i, y_out[i], mon_exp, active);
               end
            end
         end
      end
   end

   task automatic send_sample(input int inst, input logic [31:0] x0, input logic [31:0] x1);
      int n;
      @(negedge clock);
      x_in[inst]    = {x1, x0};
      x_empty[inst] = 2'b00;
      n = 0;
      #1;
      while (x_rd_en[inst] !== 1'b1 && n < 100) begin
         @(negedge clock);
         #1;
         n++;
      end
      checks++;
      if (n >= 100) begin
         failures++;
         $display("FAIL read_timeout inst=%0d got x_rd_en=%b expected=1 within 100 cycles", inst, x_rd_en[inst]);
         x_empty[inst] = 2'b11;
         return;
      end
      @(posedge clock);
      model_read(inst, x0, x1);
      @(negedge clock);
      x_empty[inst] = 2'b11;
   endtask

   task automatic wait_out(input int inst, input int target);
      int n;
      n = 0;
      while (wr_cnt[inst] < target && n < 200) begin
         @(negedge clock);
         #1;
         n++;
      end
      checks++;
      if (wr_cnt[inst] < target) begin
         failures++;
         $display("FAIL output_timeout inst=%0d got writes=%0d expected=%0d", inst, wr_cnt[inst], target);
      end
   endtask

   task automatic run_impulse(input string tag);
      int imp [4] = '{178, 293, 190, 123};
      active = 0;
      for (int k = 0; k < 4; k++) begin
         send_sample(0, (k == 0) ? 32'd1024 : 32'd0, 32'd0);
         wait_out(0, wr_cnt[0] + 1);
         checks++;
         if (last_y[0] !== {32'd0, 32'(imp[k])}) begin
            failures++;
            $display("FAIL %s_y%0d got=%h expected=%h", tag, k, last_y[0], {32'd0, 32'(imp[k])});
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < NI; i++) begin
         x_in[i]    = '0;
         x_empty[i] = 2'b11;
         y_full[i]  = 2'b00;
         rd_cnt[i]  = 0;
         wr_cnt[i]  = 0;
         last_y[i]  = '0;
      end
      model_reset();
      repeat (3) @(negedge clock);
      for (int i = 0; i < NI; i++) begin
         checks += 3;
         if (y_out[i] !== '0) begin
            failures++;
            $display("FAIL reset_y_out inst=%0d got=%h expected=0", i, y_out[i]);
         end
         if (y_wr_en[i] !== 1'b0) begin
            failures++;
            $display("FAIL reset_y_wr_en inst=%0d got=%b expected=0", i, y_wr_en[i]);
         end
         if (dbg_state[i] !== 2'd0) begin
            failures++;
            $display("FAIL reset_state inst=%0d got=%0d expected=0", i, dbg_state[i]);
         end
      end
      reset = 1'b0;
      repeat (2) @(negedge clock);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (x_rd_en[i] !== 1'b0) begin
            failures++;
            $display("FAIL idle_rd_en inst=%0d got=%b expected=0", i, x_rd_en[i]);
         end
      end
   endtask

   task automatic test_impulse();
      run_impulse("impulse");
   endtask

   task automatic test_saturate();
      logic [31:0] want [2];
      for (int inst = 1; inst <= 2; inst++) begin
         active  = inst;
         want[0] = 32'h7FFF_FFFF;
         want[1] = (inst == 1) ? 32'h7FFF_FFFF : 32'hFFFF_FFFE;
         for (int k = 0; k < 2; k++) begin
            send_sample(inst, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
            wait_out(inst, wr_cnt[inst] + 1);
            checks++;
            if (last_y[inst] !== {want[k], want[k]}) begin
               failures++;
               $display("FAIL sat_wrap inst=%0d y%0d got=%h expected=%h", inst, k, last_y[inst], {want[k], want[k]});
            end
         end
      end
   endtask

   task automatic test_decimation();
      int r0;
      int w0;
      active = 3;
      r0 = rd_cnt[3];
      w0 = wr_cnt[3];
      for (int k = 1; k <= 8; k++) send_sample(3, 32'(k << 12), 32'(k << 12));
      wait_out(3, w0 + 2);
      repeat (10) @(negedge clock);
      #1;
      checks += 3;
      if (rd_cnt[3] - r0 != 8) begin
         failures++;
         $display("FAIL dec_reads got=%0d expected=8", rd_cnt[3] - r0);
      end
      if (wr_cnt[3] - w0 != 2) begin
         failures++;
         $display("FAIL dec_writes got=%0d expected=2", wr_cnt[3] - w0);
      end
      if (last_y[3] !== {32'd13921, 32'd13921}) begin
         failures++;
         $display("FAIL dec_last_y got=%h expected=%h", last_y[3], {32'd13921, 32'd13921});
      end
   endtask

   task automatic test_empty();
      int r0;
      active = 0;
      @(negedge clock);
      x_in[0]    = {32'd5000, 32'd7000};
      x_empty[0] = 2'b10;
      r0 = rd_cnt[0];
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         #1;
         checks++;
         if (x_rd_en[0] !== 1'b0) begin
            failures++;
            $display("FAIL empty_rd_en cycle=%0d got=%b expected=0", k, x_rd_en[0]);
         end
      end
      checks++;
      if (rd_cnt[0] != r0) begin
         failures++;
         $display("FAIL empty_no_read got=%0d expected=%0d", rd_cnt[0], r0);
      end
      send_sample(0, 32'd7000, 32'd5000);
      wait_out(0, wr_cnt[0] + 1);
      checks++;
      if (rd_cnt[0] != r0 + 1) begin
         failures++;
         $display("FAIL empty_release_reads got=%0d expected=%0d", rd_cnt[0], r0 + 1);
      end
   endtask

   task automatic test_backpressure();
      logic [2*DW-1:0] y0;
      int w0;
      active = 0;
      @(negedge clock);
      y_full[0] = 2'b10;
      y0 = y_out[0];
      w0 = wr_cnt[0];
      send_sample(0, 32'd3000, -32'sd2000);
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         #1;
         checks += 2;
         if (y_wr_en[0] !== 1'b0) begin
            failures++;
            $display("FAIL full_wr_en cycle=%0d got=%b expected=0", k, y_wr_en[0]);
         end
         if (y_out[0] !== y0) begin
            failures++;
            $display("FAIL full_y_hold cycle=%0d got=%h expected=%h", k, y_out[0], y0);
         end
      end
      checks++;
      if (dbg_state[0] !== 2'd2) begin
         failures++;
         $display("FAIL full_state got=%0d expected=2", dbg_state[0]);
      end
      y_full[0] = 2'b00;
      wait_out(0, w0 + 1);
      repeat (5) @(negedge clock);
      #1;
      checks++;
      if (wr_cnt[0] != w0 + 1) begin
         failures++;
         $display("FAIL full_single_pulse got=%0d expected=%0d", wr_cnt[0], w0 + 1);
      end
   endtask

   task automatic test_reset_mid_mac();
      active = 0;
      @(negedge clock);
      x_in[0]    = {32'd0, 32'd20000};
      x_empty[0] = 2'b00;
      @(posedge clock);
      #2;
      x_empty[0] = 2'b11;
      checks++;
      if (dbg_state[0] !== 2'd1) begin
         failures++;
         $display("FAIL mid_mac_state got=%0d expected=1", dbg_state[0]);
      end
      reset = 1'b1;
      #1;
      checks += 3;
      if (y_wr_en[0] !== 1'b0) begin
         failures++;
         $display("FAIL mid_mac_reset_wr_en got=%b expected=0", y_wr_en[0]);
      end
      if (y_out[0] !== '0) begin
         failures++;
         $display("FAIL mid_mac_reset_y_out got=%h expected=0", y_out[0]);
      end
      if (dbg_state[0] !== 2'd0) begin
         failures++;
         $display("FAIL mid_mac_reset_state got=%0d expected=0", dbg_state[0]);
      end
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      run_impulse("post_reset");
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      active   = 0;
      test_reset();
      test_impulse();
      test_saturate();
      test_decimation();
      test_empty();
      test_backpressure();
      test_reset_mid_mac();
      repeat (10) @(negedge clock);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL leftover_expected got=%0d pending expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
